// File: rtl/md_pkg.sv
// Package for the multiply/divide unit.
// Holds the md_op encoding, default latencies, the 64-bit result width and
// the completion write mode carried from issue to completion.
// Optional feature macro: MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU ops
// (decoded in md_unit).
package md_pkg;

  localparam int RES_W            = 64;
  localparam int MULT_CYCLES_DEF  = 5;
  localparam int DIV_CYCLES_DEF   = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  // What happens to {HI,LO} when the in-flight operation completes.
  typedef enum logic [1:0] {
    WR_NONE = 2'd0,   // no write (divide by zero)
    WR_SET  = 2'd1,   // {HI,LO} <= pending
    WR_ADD  = 2'd2,   // {HI,LO} <= {HI,LO} + pending
    WR_SUB  = 2'd3    // {HI,LO} <= {HI,LO} - pending
  } wr_mode_t;

endpackage

// File: rtl/md_latency_counter.sv
// Latency counter for the multiply/divide unit.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   load        - load load_val (only asserted while idle)
//   load_val    - busy duration in cycles, 1..15
//   busy        - registered; high while the counter is non-zero
//   done        - high during the last busy cycle; the edge that ends it
//                 is the completion edge (counter 1 -> 0)
module md_latency_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       busy,
  output logic       done
);

  logic [3:0] cnt;

  assign done = (cnt == 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 4'd0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      busy <= (load_val != 4'd0);
    end else if (cnt != 4'd0) begin
      cnt  <= cnt - 4'd1;
      busy <= (cnt != 4'd1);
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit of the Execute stage; owns the HI/LO pair.
// The result is computed at issue and parked in a pending register; the
// latency counter only models the delay before it lands in HI/LO.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU accumulate into
// {HI,LO}); without it codes 7..10 behave as NONE.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   md_start, md_op  - issue strobe and operation code (md_pkg encoding)
//   rs_val, rt_val   - forwarded operands
//   rd_sel, rd_data  - mflo(0)/mfhi(1) select and combinational read data
//   busy             - registered, high while an operation is in flight
//   hi_out, lo_out   - architectural HI and LO
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [31:0]        hi, lo;
  logic [RES_W-1:0]   pend_res;
  wr_mode_t           pend_mode;

  logic               issue, done;
  logic               cnt_load, wr_hi, wr_lo;
  logic [3:0]         cnt_val;
  logic [RES_W-1:0]   res_c;
  wr_mode_t           mode_c;

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic        [31:0] dvs;
  logic signed [31:0] squo, srem;
  logic        [31:0] uquo, urem;

  // Issue is refused while busy: a held md_start changes nothing.
  assign issue = md_start & ~busy;

  assign sprod = 64'($signed(rs_val)) * 64'($signed(rt_val));
  assign uprod = {32'd0, rs_val} * {32'd0, rt_val};

  // Zero divisor is replaced so the dividers never see it; the write is
  // suppressed separately, leaving HI/LO untouched.
  assign dvs  = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign squo = $signed(rs_val) / $signed(dvs);
  assign srem = $signed(rs_val) % $signed(dvs);
  assign uquo = rs_val / dvs;
  assign urem = rs_val % dvs;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = 4'd0;
    res_c    = '0;
    mode_c   = WR_NONE;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    case (md_op)
      OP_MULT:  begin cnt_load = 1'b1; cnt_val = MULT_LD; mode_c = WR_SET; res_c = sprod; end
      OP_MULTU: begin cnt_load = 1'b1; cnt_val = MULT_LD; mode_c = WR_SET; res_c = uprod; end
      OP_DIV: begin
        cnt_load = 1'b1;
        cnt_val  = DIV_LD;
        res_c    = {srem, squo};
        mode_c   = (rt_val == 32'd0) ? WR_NONE : WR_SET;
      end
      OP_DIVU: begin
        cnt_load = 1'b1;
        cnt_val  = DIV_LD;
        res_c    = {urem, uquo};
        mode_c   = (rt_val == 32'd0) ? WR_NONE : WR_SET;
      end
      OP_MTHI:  wr_hi = 1'b1;
      OP_MTLO:  wr_lo = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin cnt_load = 1'b1; cnt_val = MULT_LD; mode_c = WR_ADD; res_c = sprod; end
      OP_MADDU: begin cnt_load = 1'b1; cnt_val = MULT_LD; mode_c = WR_ADD; res_c = uprod; end
      OP_MSUB:  begin cnt_load = 1'b1; cnt_val = MULT_LD; mode_c = WR_SUB; res_c = sprod; end
      OP_MSUBU: begin cnt_load = 1'b1; cnt_val = MULT_LD; mode_c = WR_SUB; res_c = uprod; end
`else
`endif
      default: ;
    endcase
  end

  md_latency_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (issue & cnt_load),
    .load_val (cnt_val),
    .busy     (busy),
    .done     (done)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= 32'd0;
      lo        <= 32'd0;
      pend_res  <= '0;
      pend_mode <= WR_NONE;
    end else begin
      if (issue && cnt_load) begin
        pend_res  <= res_c;
        pend_mode <= mode_c;
      end
      if (issue && wr_hi) hi <= rs_val;
      if (issue && wr_lo) lo <= rs_val;
      // Completion cannot coincide with an issue: issue needs busy low.
      if (done) begin
        case (pend_mode)
          WR_SET:  {hi, lo} <= pend_res;
          WR_ADD:  {hi, lo} <= {hi, lo} + pend_res;
          WR_SUB:  {hi, lo} <= {hi, lo} - pend_res;
          default: ;
        endcase
      end
    end
  end

  assign rd_data = rd_sel ? hi : lo;
  assign hi_out  = hi;
  assign lo_out  = lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit. Expected HI/LO values and busy
// durations are queued at issue and compared when busy falls.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        rd_sel;
  logic [31:0] rd_data, hi_out, lo_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  md_unit dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .busy     (busy),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one md_start pulse across a single rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_start = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    @(posedge clk);
    #1;
    md_start = 1'b0;
  endtask

  task automatic expect_result(input logic [31:0] h, input logic [31:0] l, input int cyc);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.cycles = cyc;
    sb.push_back(e);
  endtask

  // Count busy cycles (bounded), then compare against the queued entry.
  task automatic wait_done(input string tag);
    int   n;
    exp_t e;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    md_start = 1'b0;
    e = sb.pop_front();
    check({tag, " busy_cycles"}, 32'(n), 32'(e.cycles));
    check({tag, " hi"}, hi_out, e.hi);
    check({tag, " lo"}, lo_out, e.lo);
  endtask

  initial begin
    reset    = 1'b1;
    md_start = 1'b0;
    md_op    = 4'd0;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    rd_sel   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("reset hi", hi_out, 32'd0);
    check("reset lo", lo_out, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rd_data", rd_data, 32'd0);

    // MULT -3 * 7
    expect_result(32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    issue(4'd1, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult");

    // DIV -7 / 2: truncation toward zero, remainder takes dividend sign
    expect_result(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done("div");

    // DIVU by zero leaves HI/LO unchanged
    expect_result(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(4'd4, 32'd7, 32'd0);
    wait_done("divu0");

    // MTHI then mfhi on the next cycle; no busy
    issue(4'd5, 32'h1234_5678, 32'd0);
    check("mthi busy", {31'd0, busy}, 32'd0);
    rd_sel = 1'b1;
    @(negedge clk);
    check("mfhi rd_data", rd_data, 32'h1234_5678);
    check("mthi busy later", {31'd0, busy}, 32'd0);
    rd_sel = 1'b0;
    #1;
    check("mflo rd_data", rd_data, 32'hFFFF_FFFD);

    // MULTU with MTLO held during busy: the MTLO is ignored
    expect_result(32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    md_start = 1'b1;
    md_op    = 4'd6;
    rs_val   = 32'h0000_00AA;
    #1;
    check("read during busy", rd_data, 32'hFFFF_FFFD);
    wait_done("multu");

    // Reset in the 4th busy cycle of a DIV aborts it
    issue(4'd3, 32'd100, 32'd3);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", hi_out, 32'd0);
    check("abort lo", lo_out, 32'd0);
    repeat (15) @(negedge clk);
    check("no late write hi", hi_out, 32'd0);
    check("no late write lo", lo_out, 32'd0);
    check("no late busy", {31'd0, busy}, 32'd0);

    // DIV 100 / -7 -> q=-14, r=2
    expect_result(32'h0000_0002, 32'hFFFF_FFF2, 10);
    issue(4'd3, 32'd100, 32'hFFFF_FFF9);
    wait_done("div neg divisor");

    // MADDU 1*1 onto HI=0, LO=0xFFFFFFFF
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
`ifdef MDU_MADD_EN
    expect_result(32'h0000_0001, 32'h0000_0000, 5);
    issue(4'd8, 32'd1, 32'd1);
    wait_done("maddu");
`else
    issue(4'd8, 32'd1, 32'd1);
    check("maddu off busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("maddu off hi", hi_out, 32'd0);
    check("maddu off lo", lo_out, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
